// File: rtl/key_command_encoder_pkg.sv
// rtl/key_command_encoder_pkg.sv - shared command codes, key FSM states and sizing helper
package key_command_encoder_pkg;

  // Default-width command codes: key i maps to {1'b1, i}, zero means no command
  localparam logic [2:0] CMD_NONE  = 3'b000;
  localparam logic [2:0] CMD_DOWN  = 3'b100;
  localparam logic [2:0] CMD_LEFT  = 3'b101;
  localparam logic [2:0] CMD_RIGHT = 3'b110;
  localparam logic [2:0] CMD_UP    = 3'b111;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_DELAY  = 2'd1,
    KS_REPEAT = 2'd2,
    KS_HELD   = 2'd3
  } key_state_t;

  // Bits needed to hold values 0..max_val-1, never less than one bit
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/key_command_encoder_if.sv
// rtl/key_command_encoder_if.sv - command valid/ready handshake toward the game controller
interface key_command_encoder_if #(
  parameter int CODE_W = 3
);
  logic              cmd_valid;
  logic [CODE_W-1:0] cmd_code;
  logic              cmd_ready;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/key_repeat_fsm.sv
// rtl/key_repeat_fsm.sv - per-key press detection with delayed auto-repeat
module key_repeat_fsm
  import key_command_encoder_pkg::*;
#(
  parameter int DAS_TICKS = 20,
  parameter int ARR_TICKS = 5,
  parameter bit REPEAT_ON = 1'b1
) (
  input  logic clk,
  input  logic clrn,
  input  logic flush,
  input  logic tick,
  input  logic key,
  input  logic key_prev,
  output logic emit
);

  localparam int CNT_W = cnt_width((DAS_TICKS > ARR_TICKS) ? DAS_TICKS : ARR_TICKS);
  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_TICKS - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_TICKS - 1);

  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and tick counter registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= KS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and one-shot emit; a released key always drops back to idle silently
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    if (flush || !key) begin
      state_d = KS_IDLE;
    end else begin
      case (state_q)
        KS_IDLE: begin
          if (!key_prev) begin
            emit    = 1'b1;
            cnt_d   = '0;
            state_d = REPEAT_ON ? KS_DELAY : KS_HELD;
          end
        end
        KS_DELAY: begin
          if (tick) begin
            if (cnt_q == DAS_LAST) begin
              emit    = 1'b1;
              cnt_d   = '0;
              state_d = KS_REPEAT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        KS_REPEAT: begin
          if (tick) begin
            if (cnt_q == ARR_LAST) begin
              emit  = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/key_command_encoder.sv
// rtl/key_command_encoder.sv - key levels to prioritised one-shot commands with FIFO and game reset pulse
module key_command_encoder
  import key_command_encoder_pkg::*;
#(
  parameter int               N_KEYS     = 4,
  parameter int               CODE_W     = 3,
  parameter int               TICK_DIV   = 1000000,
  parameter int               DAS_TICKS  = 20,
  parameter int               ARR_TICKS  = 5,
  parameter logic [N_KEYS-1:0] REPEAT_EN = 4'b0111,
  parameter int               FIFO_DEPTH = 4,
  parameter int               RST_PULSE  = 4
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic [N_KEYS-1:0]      keys,
  input  logic                   rst_key,
  key_command_encoder_if.master  cmd_if,
  output logic                   game_rst_n,
  output logic                   ovf
);

  localparam int PRE_W = cnt_width(TICK_DIV);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int RC_W  = cnt_width(RST_PULSE);

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [N_KEYS-1:0] key_prev_q, key_prev_d;
  logic              rst_prev_q, rst_prev_d;
  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  logic              ovf_q, ovf_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic              game_rst_n_q, game_rst_n_d;
  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];

  logic              tick, flush, push, push_ok, pop, empty, full;
  logic [N_KEYS-1:0] emit;
  logic [CODE_W-2:0] win_idx;
  logic [CODE_W-1:0] win_code;

  assign tick  = (presc_q == PRE_W'(TICK_DIV - 1));
  assign flush = rst_key && !rst_prev_q;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_repeat_fsm #(
      .DAS_TICKS (DAS_TICKS),
      .ARR_TICKS (ARR_TICKS),
      .REPEAT_ON (REPEAT_EN[g])
    ) u_fsm (
      .clk      (clk),
      .clrn     (clrn),
      .flush    (flush),
      .tick     (tick),
      .key      (keys[g]),
      .key_prev (key_prev_q[g]),
      .emit     (emit[g])
    );
  end

  // Fixed priority: lowest key index wins, losers are discarded rather than queued
  always_comb begin
    push    = 1'b0;
    win_idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (emit[i]) begin
        push    = !flush;
        win_idx = (CODE_W-1)'(i);
      end
    end
    win_code = {1'b1, win_idx};
  end

  // Prescaler, edge history, FIFO pointers, overflow flag and reset-pulse countdown
  always_comb begin
    presc_d    = tick ? '0 : presc_q + 1'b1;
    key_prev_d = flush ? '1 : keys;
    rst_prev_d = rst_key;
    empty      = (wr_q == rd_q);
    full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop        = !empty && cmd_if.cmd_ready;
    push_ok    = push && (!full || pop);
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      ovf_d = 1'b0;
    end else begin
      wr_d  = wr_q + (AW+1)'(push_ok);
      rd_d  = rd_q + (AW+1)'(pop);
      ovf_d = ovf_q || (push && full && !pop);
    end
    if (flush) begin
      rst_cnt_d    = RC_W'(RST_PULSE - 1);
      game_rst_n_d = 1'b0;
    end else if (rst_cnt_q != '0) begin
      rst_cnt_d    = rst_cnt_q - 1'b1;
      game_rst_n_d = 1'b0;
    end else begin
      rst_cnt_d    = '0;
      game_rst_n_d = 1'b1;
    end
  end

  // Control registers; edge history resets to ones so keys held through reset stay silent
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      presc_q      <= '0;
      key_prev_q   <= '1;
      rst_prev_q   <= 1'b1;
      wr_q         <= '0;
      rd_q         <= '0;
      ovf_q        <= 1'b0;
      rst_cnt_q    <= '0;
      game_rst_n_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      key_prev_q   <= key_prev_d;
      rst_prev_q   <= rst_prev_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      ovf_q        <= ovf_d;
      rst_cnt_q    <= rst_cnt_d;
      game_rst_n_q <= game_rst_n_d;
    end
  end

  // FIFO storage; contents are only observed while the pointers say non-empty
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q[AW-1:0]] <= win_code;
    end
  end

  assign cmd_if.cmd_valid = !empty;
  assign cmd_if.cmd_code  = empty ? CODE_W'(CMD_NONE) : mem_q[rd_q[AW-1:0]];
  assign game_rst_n       = game_rst_n_q;
  assign ovf              = ovf_q;

endmodule
